// File: rtl/frag_buffer_pkg.sv
// frag_buffer_pkg: shared sizing and beat type for the TX arbiter, fragment buffer and fragmentation FSM
package frag_buffer_pkg;
  localparam int BEAT_W = 32;
  localparam int DEPTH = 64;
  localparam int NUM_WR_LOC = 8;
  localparam int NUM_RD_LOC = 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/frag_buffer_ptr_ctrl.sv
// frag_buffer_ptr_ctrl: pointers, occupancy count and accept checks for frag_data_buffer
// Ports: clk, arst (async, active-high); wr_en/no_loc_wr and rd_en/no_loc_rd requests;
// wr_ptr, rd_ptr, count registered state; wr_acc marks an accepted write this cycle.
// With FRAG_BUF_ERR_FLAGS_EN defined: sticky ovf_err/udf_err for dropped oversize writes/pops.
module frag_buffer_ptr_ctrl
  import frag_buffer_pkg::*;
#(
  parameter int DEPTH = frag_buffer_pkg::DEPTH,
  parameter int NUM_WR_LOC = frag_buffer_pkg::NUM_WR_LOC,
  parameter int NUM_RD_LOC = frag_buffer_pkg::NUM_RD_LOC,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int WW = $clog2(NUM_WR_LOC + 1),
  localparam int RW = $clog2(NUM_RD_LOC + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          wr_en,
  input  logic [WW-1:0] no_loc_wr,
  input  logic          rd_en,
  input  logic [RW-1:0] no_loc_rd,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          wr_acc
`ifdef FRAG_BUF_ERR_FLAGS_EN
  ,
  output logic          ovf_err,
  output logic          udf_err
`endif
);
  logic [CW-1:0] free, wr_amt, rd_amt;
  logic wr_big, rd_big, rd_acc;
  // Both checks use the registered count only; a same-cycle pop never makes room for a write.
  always_comb begin
    free = CW'(DEPTH) - count;
    wr_big = no_loc_wr > WW'(NUM_WR_LOC) || CW'(no_loc_wr) > free;
    rd_big = no_loc_rd > RW'(NUM_RD_LOC) || CW'(no_loc_rd) > count;
    wr_acc = wr_en && no_loc_wr != '0 && !wr_big;
    rd_acc = rd_en && no_loc_rd != '0 && !rd_big;
    wr_amt = wr_acc ? CW'(no_loc_wr) : '0;
    rd_amt = rd_acc ? CW'(no_loc_rd) : '0;
  end
  // DEPTH is a power of two, so pointer wrap is plain overflow of PW bits.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_amt);
      rd_ptr <= rd_ptr + PW'(rd_amt);
      count <= count + wr_amt - rd_amt;
    end
  end
`ifdef FRAG_BUF_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err | (wr_en & wr_big);
      udf_err <= udf_err | (rd_en & rd_big);
    end
  end
`endif
endmodule

// File: rtl/frag_data_buffer.sv
// frag_data_buffer: location-granular circular buffer between TX arbiter and fragmentation FSM
// Ports: clk, arst (async, active-high);
// write side: wr_en, no_loc_wr, data_in (location 0 in low bits), empty_loc free count;
// read side: rd_en, no_loc_rd, data_out (slot 0 = oldest, first-word-fall-through), occ_loc, empty_buffer.
// Optional macro FRAG_BUF_ERR_FLAGS_EN adds sticky ovf_err/udf_err outputs.
module frag_data_buffer
  import frag_buffer_pkg::*;
#(
  parameter int BEAT_W = frag_buffer_pkg::BEAT_W,
  parameter int DEPTH = frag_buffer_pkg::DEPTH,
  parameter int NUM_WR_LOC = frag_buffer_pkg::NUM_WR_LOC,
  parameter int NUM_RD_LOC = frag_buffer_pkg::NUM_RD_LOC,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int WW = $clog2(NUM_WR_LOC + 1),
  localparam int RW = $clog2(NUM_RD_LOC + 1)
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         wr_en,
  input  logic [WW-1:0]                no_loc_wr,
  input  logic [NUM_WR_LOC*BEAT_W-1:0] data_in,
  output logic [CW-1:0]                empty_loc,
  input  logic                         rd_en,
  input  logic [RW-1:0]                no_loc_rd,
  output logic [NUM_RD_LOC*BEAT_W-1:0] data_out,
  output logic [CW-1:0]                occ_loc,
  output logic                         empty_buffer
`ifdef FRAG_BUF_ERR_FLAGS_EN
  ,
  output logic                         ovf_err,
  output logic                         udf_err
`endif
);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic wr_acc;
  logic [BEAT_W-1:0] mem [DEPTH];
  frag_buffer_ptr_ctrl #(
    .DEPTH(DEPTH),
    .NUM_WR_LOC(NUM_WR_LOC),
    .NUM_RD_LOC(NUM_RD_LOC)
  ) u_ctrl (
    .clk(clk),
    .arst(arst),
    .wr_en(wr_en),
    .no_loc_wr(no_loc_wr),
    .rd_en(rd_en),
    .no_loc_rd(no_loc_rd),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count),
    .wr_acc(wr_acc)
`ifdef FRAG_BUF_ERR_FLAGS_EN
    ,
    .ovf_err(ovf_err),
    .udf_err(udf_err)
`endif
  );
  // Each incoming location lands at wr_ptr+i; PW-bit addition wraps across DEPTH-1 -> 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_WR_LOC; i++)
        if (WW'(i) < no_loc_wr) mem[wr_ptr + PW'(i)] <= data_in[i*BEAT_W +: BEAT_W];
    end
  end
  for (genvar j = 0; j < NUM_RD_LOC; j++) begin : g_rd
    assign data_out[j*BEAT_W +: BEAT_W] = mem[rd_ptr + PW'(j)];
  end
  assign empty_loc = CW'(DEPTH) - count;
  assign occ_loc = count;
  assign empty_buffer = count == '0;
endmodule

// File: tb/tb_frag_data_buffer.sv
// tb_frag_data_buffer: directed plus randomized bench for frag_data_buffer against a queue model
module tb_frag_data_buffer;
  localparam int BW = 32;
  localparam int D = 64;
  localparam int NW = 8;
  localparam int NR = 8;
  localparam int DW = NW * BW;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [3:0] no_loc_wr = '0;
  logic [3:0] no_loc_rd = '0;
  logic [DW-1:0] data_in = '0;
  logic [NR*BW-1:0] data_out;
  logic [6:0] empty_loc, occ_loc;
  logic empty_buffer;
`ifdef FRAG_BUF_ERR_FLAGS_EN
  logic ovf_err, udf_err;
`endif
  always #5 clk = ~clk;
  frag_data_buffer dut (
    .clk(clk),
    .arst(arst),
    .wr_en(wr_en),
    .no_loc_wr(no_loc_wr),
    .data_in(data_in),
    .empty_loc(empty_loc),
    .rd_en(rd_en),
    .no_loc_rd(no_loc_rd),
    .data_out(data_out),
    .occ_loc(occ_loc),
    .empty_buffer(empty_buffer)
`ifdef FRAG_BUF_ERR_FLAGS_EN
    ,
    .ovf_err(ovf_err),
    .udf_err(udf_err)
`endif
  );
  logic [BW-1:0] q[$];
  bit m_ovf, m_udf, chk_on;
  int n_cmp = 0;
  int n_bad = 0;
  int sz, nw_i, nr_i;
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference: a FIFO of beats; a pop takes from the front of the pre-edge contents, a write appends.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      sz = q.size();
      nw_i = int'(no_loc_wr);
      nr_i = int'(no_loc_rd);
      if (wr_en && (nw_i > NW || nw_i > D - sz)) m_ovf = 1;
      if (rd_en && (nr_i > NR || nr_i > sz)) m_udf = 1;
      if (rd_en && nr_i != 0 && nr_i <= NR && nr_i <= sz)
        repeat (nr_i) void'(q.pop_front());
      if (wr_en && nw_i != 0 && nw_i <= NW && nw_i <= D - sz)
        for (int i = 0; i < nw_i; i++) q.push_back(data_in[i*BW +: BW]);
    end
  end
  always @(negedge clk) begin
    if (!arst && chk_on) begin
      chk("occ_loc", occ_loc, q.size());
      chk("empty_loc", empty_loc, D - q.size());
      chk("empty_buffer", empty_buffer, q.size() == 0);
      for (int j = 0; j < NR; j++)
        if (j < q.size()) chk($sformatf("data_out slot%0d", j), data_out[j*BW +: BW], q[j]);
`ifdef FRAG_BUF_ERR_FLAGS_EN
      chk("ovf_err", ovf_err, m_ovf);
      chk("udf_err", udf_err, m_udf);
`endif
    end
  end
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*BW +: BW] = $urandom;
    return d;
  endfunction
  function automatic logic [DW-1:0] seq_data(int base);
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*BW +: BW] = BW'(base + i);
    return d;
  endfunction
  // Drive one cycle of requests; returns at the following negedge, after the capturing posedge.
  task automatic step(bit we, int nw, bit re, int nr, logic [DW-1:0] d);
    wr_en = we;
    no_loc_wr = 4'(nw);
    rd_en = re;
    no_loc_rd = 4'(nr);
    data_in = d;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end
  initial begin
    #12;
    chk("reset empty_loc", empty_loc, 64);
    chk("reset occ_loc", occ_loc, 0);
    chk("reset empty_buffer", empty_buffer, 1);
    chk("reset data_out", data_out, 0);
    arst = 1'b0;
    @(negedge clk);
    chk_on = 1;
    step(1, 8, 0, 0, seq_data(0));
    chk("wr8 occ_loc", occ_loc, 8);
    chk("wr8 empty_loc", empty_loc, 56);
    for (int j = 0; j < NR; j++) chk($sformatf("wr8 slot%0d", j), data_out[j*BW +: BW], j);
    step(0, 0, 1, 3, '0);
    chk("pop3 occ_loc", occ_loc, 5);
    chk("pop3 slot0", data_out[BW-1:0], 3);
    repeat (6) step(1, 8, 0, 0, rnd_data());
    step(1, 7, 0, 0, rnd_data());
    chk("fill occ_loc", occ_loc, 60);
    step(1, 8, 0, 0, rnd_data());
    chk("drop occ_loc", occ_loc, 60);
`ifdef FRAG_BUF_ERR_FLAGS_EN
    chk("drop ovf_err", ovf_err, 1);
`endif
    step(1, 4, 0, 0, rnd_data());
    chk("full empty_loc", empty_loc, 0);
    chk("full occ_loc", occ_loc, 64);
    chk("full slot0", data_out[BW-1:0], 3);
    chk("full slot4", data_out[4*BW +: BW], 7);
    repeat (8) step(0, 0, 1, 8, '0);
    chk("drain empty_buffer", empty_buffer, 1);
    repeat (7) begin
      step(1, 8, 0, 0, rnd_data());
      step(0, 0, 1, 8, '0);
    end
    step(1, 3, 0, 0, rnd_data());
    step(0, 0, 1, 3, '0);
    step(1, 8, 0, 0, seq_data('hA0));
    for (int j = 0; j < NR; j++) chk($sformatf("wrap slot%0d", j), data_out[j*BW +: BW], 'hA0 + j);
    step(0, 0, 1, 8, '0);
    chk("wrap pop occ_loc", occ_loc, 0);
    step(1, 4, 0, 0, rnd_data());
    step(1, 6, 1, 4, rnd_data());
    chk("simul occ_loc", occ_loc, 6);
    step(0, 0, 1, 7, '0);
    chk("pop7 occ_loc", occ_loc, 6);
`ifdef FRAG_BUF_ERR_FLAGS_EN
    chk("pop7 udf_err", udf_err, 1);
`endif
    for (int p = 0; p < 3; p++)
      repeat (500) begin
        int wp = p == 0 ? 80 : p == 1 ? 50 : 25;
        step($urandom_range(0, 99) < wp, $urandom_range(0, 10),
             $urandom_range(0, 99) >= wp, $urandom_range(0, 10), rnd_data());
      end
    step(1, 8, 0, 0, rnd_data());
    step(1, 5, 1, 2, rnd_data());
    #3;
    arst = 1'b1;
    #1;
    chk("midrst occ_loc", occ_loc, 0);
    chk("midrst empty_loc", empty_loc, 64);
    chk("midrst empty_buffer", empty_buffer, 1);
    chk("midrst data_out", data_out, 0);
`ifdef FRAG_BUF_ERR_FLAGS_EN
    chk("midrst ovf_err", ovf_err, 0);
    chk("midrst udf_err", udf_err, 0);
`endif
    @(negedge clk);
    arst = 1'b0;
    step(1, 2, 0, 0, seq_data('h55));
    chk("postrst occ_loc", occ_loc, 2);
    chk("postrst slot1", data_out[BW +: BW], 'h56);
    step(0, 0, 0, 0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frag_data_buffer.md
Name: frag_data_buffer

Overview:
Location-granular circular buffer between the TX arbiter and the data-fragmentation FSM. The arbiter writes 1..NUM_WR_LOC double-word locations per cycle and gates its writes on a free-location count. The fragmentation FSM sees the oldest NUM_RD_LOC locations first-word-fall-through and pops 1..NUM_RD_LOC locations per cycle.

Parameters:
BEAT_W, 32, bits per location (one DW)
DEPTH, 64, number of locations; power of two, >= 2*max(NUM_WR_LOC, NUM_RD_LOC)
NUM_WR_LOC, 8, max locations written per cycle
NUM_RD_LOC, 8, max locations popped per cycle

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
wr_en  in  1  write strobe
no_loc_wr  in  $clog2(NUM_WR_LOC+1)  locations to write this cycle
data_in  in  NUM_WR_LOC*BEAT_W  location 0 in bits [BEAT_W-1:0], and so on upward
empty_loc  out  $clog2(DEPTH+1)  free locations, registered
rd_en  in  1  pop strobe
no_loc_rd  in  $clog2(NUM_RD_LOC+1)  locations to pop this cycle
data_out  out  NUM_RD_LOC*BEAT_W  oldest locations; slot 0 = head
occ_loc  out  $clog2(DEPTH+1)  occupied locations, registered
empty_buffer  out  1  occ_loc==0

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, count=0, memory cleared.
  - Outputs at reset: empty_loc=DEPTH, occ_loc=0, empty_buffer=1, data_out=0.
- Write:
  - Accepted when wr_en && no_loc_wr!=0 && no_loc_wr<=NUM_WR_LOC && no_loc_wr<=empty_loc.
  - On accept, location i (i<no_loc_wr) is stored at mem[(wr_ptr+i) mod DEPTH], then wr_ptr += no_loc_wr, wrapping modulo DEPTH.
  - Otherwise the whole write is dropped; no partial writes.
- Read:
  - data_out slot j = mem[(rd_ptr+j) mod DEPTH], combinational from registered state.
  - Slots j>=occ_loc are don't-care.
  - Pop accepted when rd_en && no_loc_rd!=0 && no_loc_rd<=NUM_RD_LOC && no_loc_rd<=occ_loc; then rd_ptr += no_loc_rd, wrapping.
  - Otherwise the pop is ignored.
- Latency:
  - A location written in cycle N is visible on data_out and counted in occ_loc from cycle N+1.
  - A pop in cycle N frees space in empty_loc from cycle N+1.
- Simultaneous write and pop:
  - Each is checked against the current registered count; no same-cycle crediting.
  - count_next = count + acc_wr - acc_rd.
  - empty_loc = DEPTH - count and occ_loc = count, both derived from the registered count.
  - A pop may occur on a full buffer while a write occurs on an empty buffer in the same cycle only if each passes its own check.
- Wrap-around: multi-location writes and reads spanning the DEPTH-1 to 0 boundary are split per location by modular indexing.
- Count width is $clog2(DEPTH+1), so full (count=DEPTH) is distinct from empty.
- Reset mid-operation: everything returns to the reset state asynchronously and all stored data is discarded.

Optional Feature:
Macro FRAG_BUF_ERR_FLAGS_EN.
- When defined, two extra outputs exist:
  - ovf_err (1b): sticky, set in the cycle after a write is dropped because no_loc_wr>empty_loc or no_loc_wr>NUM_WR_LOC.
  - udf_err (1b): sticky, set after a pop is dropped because no_loc_rd>occ_loc or no_loc_rd>NUM_RD_LOC.
  - Both clear only on arst; reset value 0.
- When undefined, neither the ports nor the logic exist, and drops are silent.
- Data-path behaviour is identical either way.

Decomposition:
- Package frag_buffer_pkg holds:
  - default BEAT_W, DEPTH, NUM_WR_LOC and NUM_RD_LOC;
  - derived widths PTR_W=$clog2(DEPTH) and CNT_W=$clog2(DEPTH+1);
  - a beat_t typedef, logic [BEAT_W-1:0].
- The package is shared with the arbiter and the fragmentation FSM.
- One sub-module is natural: frag_buffer_ptr_ctrl, which holds the pointers, the count, the accept checks and the error flags.
- The storage array and read mux stay in the top module.

Test Plan:
1. Reset, then idle: empty_loc=64, occ_loc=0, empty_buffer=1, data_out=0.
2. Write no_loc_wr=8 with data 0x0..0x7 -> next cycle occ_loc=8, empty_loc=56, data_out slots 0..7 = 0x0..0x7.
3. Pop no_loc_rd=3 -> next cycle occ_loc=5 and slot0=0x3.
4. Fill to 60 locations, then write 8 -> dropped, count stays 60, and with the macro ovf_err=1.
   - Write 4 -> full: empty_loc=0, and data_out reads back in order.
5. Wrap: with rd_ptr=wr_ptr=62, write 8 locations 0xA0..0xA7 -> stored at 62,63,0..5; pop 8 -> data_out slots 0..7 = 0xA0..0xA7 in order.
6. With occ_loc=4, apply a simultaneous write of 6 and pop of 4 -> next occ_loc=6.
   - Then a pop of 7 -> ignored, occ_loc stays 6, and with the macro udf_err=1.
   - Assert arst mid-stream -> occ_loc=0 and both flags=0 immediately.
